// File: rtl/branch_target_stage.sv
// -----------------------------------------------------------------------------
// branch_target_stage
//
// Registered branch-resolution stage at the ID/EX boundary. It takes the
// sign-extended immediate, scales it by four, adds it to PC+4 to form the
// branch target, and compares the two register operands to decide whether
// the branch is taken. A taken branch raises a single-cycle redirect request
// toward IF, even while the stage is held by a multi-cycle stall.
//
// Optional feature macro: BRANCH_STATS_EN
//   Defined   : retired-branch and taken-branch counters are generated.
//   Undefined : br_count_o / tk_count_o are tied to zero.
//
// Parameters
//   DATA_W  width of PC, immediate and operand buses
//   STAT_W  width of the statistics counters
//
// Ports
//   clk_i       system clock, rising edge
//   rst_i       synchronous reset, active-high (beats flush and stall)
//   valid_i     upstream instruction valid
//   stall_i     hold stage contents
//   flush_i     squash the instruction in the stage (beats stall)
//   branch_i    instruction is a conditional branch
//   br_type_i   00=BEQ 01=BNE 10=BLEZ 11=BGTZ
//   pc_plus4_i  PC+4 of the instruction
//   imm_ext_i   sign-extended offset, unshifted
//   rs_data_i   first operand
//   rt_data_i   second operand (unused by BLEZ/BGTZ)
//   valid_o     stage holds a live instruction
//   taken_o     registered branch decision
//   target_o    registered branch target
//   pc_plus4_o  registered PC+4 passthrough
//   redirect_o  one-shot PC redirect request
//   br_count_o  branches retired
//   tk_count_o  taken branches retired
// -----------------------------------------------------------------------------
module branch_target_stage #(
    parameter int DATA_W = 32,
    parameter int STAT_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              branch_i,
    input  logic [1:0]        br_type_i,
    input  logic [DATA_W-1:0] pc_plus4_i,
    input  logic [DATA_W-1:0] imm_ext_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    output logic              valid_o,
    output logic              taken_o,
    output logic [DATA_W-1:0] target_o,
    output logic [DATA_W-1:0] pc_plus4_o,
    output logic              redirect_o,
    output logic [STAT_W-1:0] br_count_o,
    output logic [STAT_W-1:0] tk_count_o
);

    localparam logic [1:0] BR_BEQ  = 2'b00;
    localparam logic [1:0] BR_BNE  = 2'b01;
    localparam logic [1:0] BR_BLEZ = 2'b10;
    localparam logic [1:0] BR_BGTZ = 2'b11;

    // Word offset to byte offset; the top two immediate bits fall off and the
    // carry out of the add is dropped, so the result wraps modulo 2^DATA_W.
    function automatic logic [DATA_W-1:0] calc_target(
        input logic [DATA_W-1:0] pc_plus4,
        input logic [DATA_W-1:0] imm
    );
        logic [DATA_W-1:0] offset;
        offset = imm << 2;
        return pc_plus4 + offset;
    endfunction

    function automatic logic branch_decide(
        input logic [1:0]        br_type,
        input logic [DATA_W-1:0] rs,
        input logic [DATA_W-1:0] rt
    );
        logic signed [DATA_W-1:0] rs_s;
        logic                     result;
        rs_s   = signed'(rs);
        result = 1'b0;
        case (br_type)
            BR_BEQ:  result = (rs == rt);
            BR_BNE:  result = (rs != rt);
            BR_BLEZ: result = (rs_s <= 0);
            BR_BGTZ: result = (rs_s > 0);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    // ---- stage p0: combinational target and decision from the inputs ----
    logic [DATA_W-1:0] target_p0;
    logic              taken_p0;
    logic              load_p0;

    assign target_p0 = calc_target(pc_plus4_i, imm_ext_i);
    assign taken_p0  = valid_i & branch_i & branch_decide(br_type_i, rs_data_i, rt_data_i);
    assign load_p0   = ~flush_i & ~stall_i;

    // ---- stage p1: registered stage contents ----
    logic              vld_p1;
    logic              taken_p1;
    logic [DATA_W-1:0] target_p1;
    logic [DATA_W-1:0] pc_plus4_p1;
    logic              redirect_done_p1;
    logic              redirect_p1;

    // Redirect fires once per held instruction; redirect_done remembers that
    // IF has already been told while the stage is stalled.
    assign redirect_p1 = vld_p1 & taken_p1 & ~redirect_done_p1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1           <= 1'b0;
            taken_p1         <= 1'b0;
            target_p1        <= '0;
            pc_plus4_p1      <= '0;
            redirect_done_p1 <= 1'b0;
        end else if (flush_i) begin
            vld_p1           <= 1'b0;
            taken_p1         <= 1'b0;
            redirect_done_p1 <= 1'b0;
        end else if (stall_i) begin
            if (redirect_p1) begin
                redirect_done_p1 <= 1'b1;
            end
        end else begin
            vld_p1           <= valid_i;
            taken_p1         <= taken_p0;
            target_p1        <= target_p0;
            pc_plus4_p1      <= pc_plus4_i;
            redirect_done_p1 <= 1'b0;
        end
    end

    assign valid_o    = vld_p1;
    assign taken_o    = taken_p1;
    assign target_o   = target_p1;
    assign pc_plus4_o = pc_plus4_p1;
    assign redirect_o = redirect_p1;

`ifdef BRANCH_STATS_EN
    logic              is_branch_p1;
    logic              retire_p1;
    logic [STAT_W-1:0] br_cnt_p1;
    logic [STAT_W-1:0] tk_cnt_p1;

    // An instruction retires when it leaves the stage by being replaced by a
    // load, i.e. it was live and was neither held nor squashed.
    assign retire_p1 = vld_p1 & load_p0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            is_branch_p1 <= 1'b0;
            br_cnt_p1    <= '0;
            tk_cnt_p1    <= '0;
        end else begin
            if (load_p0) begin
                is_branch_p1 <= branch_i;
            end
            if (retire_p1) begin
                if (is_branch_p1) begin
                    br_cnt_p1 <= br_cnt_p1 + 1'b1;
                end
                if (taken_p1) begin
                    tk_cnt_p1 <= tk_cnt_p1 + 1'b1;
                end
            end
        end
    end

    assign br_count_o = br_cnt_p1;
    assign tk_count_o = tk_cnt_p1;
`else
    logic unused_load;
    assign unused_load = load_p0;
    assign br_count_o  = '0;
    assign tk_count_o  = '0;
`endif

endmodule

// File: tb/tb_branch_target_stage.sv
// -----------------------------------------------------------------------------
// tb_branch_target_stage
//
// Self-checking bench for branch_target_stage: a table of directed branch
// vectors, hand sequences for stall/flush/reset/statistics corner cases, and
// randomized traffic compared each cycle against a behavioural model.
// Build with +define+BRANCH_STATS_EN to expect live statistics counters.
// -----------------------------------------------------------------------------
module tb_branch_target_stage;

    localparam int DATA_W = 32;
    localparam int STAT_W = 32;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              valid_i;
    logic              stall_i;
    logic              flush_i;
    logic              branch_i;
    logic [1:0]        br_type_i;
    logic [DATA_W-1:0] pc_plus4_i;
    logic [DATA_W-1:0] imm_ext_i;
    logic [DATA_W-1:0] rs_data_i;
    logic [DATA_W-1:0] rt_data_i;
    logic              valid_o;
    logic              taken_o;
    logic [DATA_W-1:0] target_o;
    logic [DATA_W-1:0] pc_plus4_o;
    logic              redirect_o;
    logic [STAT_W-1:0] br_count_o;
    logic [STAT_W-1:0] tk_count_o;

    branch_target_stage #(.DATA_W(DATA_W), .STAT_W(STAT_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .branch_i   (branch_i),
        .br_type_i  (br_type_i),
        .pc_plus4_i (pc_plus4_i),
        .imm_ext_i  (imm_ext_i),
        .rs_data_i  (rs_data_i),
        .rt_data_i  (rt_data_i),
        .valid_o    (valid_o),
        .taken_o    (taken_o),
        .target_o   (target_o),
        .pc_plus4_o (pc_plus4_o),
        .redirect_o (redirect_o),
        .br_count_o (br_count_o),
        .tk_count_o (tk_count_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model of what the stage should be presenting.
    logic        m_v, m_t, m_done, m_isbr;
    logic [31:0] m_target, m_pc;
    int unsigned m_br, m_tk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic model_decide(input logic [1:0] bt, input logic [31:0] rs,
                                          input logic [31:0] rt);
        int srs;
        srs = int'(rs);
        case (bt)
            2'd0:    return rs == rt;
            2'd1:    return rs != rt;
            2'd2:    return srs <= 0;
            default: return srs > 0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        logic redir;
        redir = m_v & m_t & ~m_done;
        if (rst_i) begin
            m_v = 0; m_t = 0; m_done = 0; m_isbr = 0;
            m_target = 0; m_pc = 0; m_br = 0; m_tk = 0;
        end else if (flush_i) begin
            m_v = 0; m_t = 0; m_done = 0;
        end else if (stall_i) begin
            if (redir) m_done = 1;
        end else begin
            if (m_v) begin
                if (m_isbr) m_br = m_br + 1;
                if (m_t)    m_tk = m_tk + 1;
            end
            m_v      = valid_i;
            m_t      = valid_i & branch_i & model_decide(br_type_i, rs_data_i, rt_data_i);
            m_target = pc_plus4_i + imm_ext_i * 32'd4;
            m_pc     = pc_plus4_i;
            m_isbr   = branch_i;
            m_done   = 0;
        end
    endtask

    task automatic cmp_model(input string tag);
        logic [31:0] eb, et;
`ifdef BRANCH_STATS_EN
        eb = m_br; et = m_tk;
`else
        eb = 0; et = 0;
`endif
        chk({tag, ".valid"},    valid_o,    m_v);
        chk({tag, ".taken"},    taken_o,    m_t);
        chk({tag, ".redirect"}, redirect_o, m_v & m_t & ~m_done);
        chk({tag, ".br_count"}, br_count_o, eb);
        chk({tag, ".tk_count"}, tk_count_o, et);
        if (m_v) begin
            chk({tag, ".target"}, target_o,   m_target);
            chk({tag, ".pc4"},    pc_plus4_o, m_pc);
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        cmp_model(tag);
    endtask

    task automatic drive(input logic v, input logic br, input logic [1:0] bt,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs, input logic [31:0] rt);
        rst_i = 0; stall_i = 0; flush_i = 0;
        valid_i = v; branch_i = br; br_type_i = bt;
        pc_plus4_i = pc; imm_ext_i = imm; rs_data_i = rs; rt_data_i = rt;
    endtask

    task automatic do_reset();
        rst_i = 1; stall_i = 1; flush_i = 0; valid_i = 1; branch_i = 1;
        tick("reset");
        rst_i = 0;
    endtask

    typedef struct {
        logic [1:0]  bt;
        logic        br;
        logic [31:0] pc, imm, rs, rt;
        logic        exp_tk;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        m_v = 0; m_t = 0; m_done = 0; m_isbr = 0;
        m_target = 0; m_pc = 0; m_br = 0; m_tk = 0;
        drive(0, 0, 0, 0, 0, 0, 0);

        tbl[0] = '{2'd0, 1, 32'h0040_0010, 32'h0000_0003, 32'd5, 32'd5, 1, 32'h0040_001C};
        tbl[1] = '{2'd1, 1, 32'h0040_0020, 32'hFFFF_FFFE, 32'd1, 32'd2, 1, 32'h0040_0018};
        tbl[2] = '{2'd1, 1, 32'h0040_0020, 32'hFFFF_FFFE, 32'd7, 32'd7, 0, 32'h0040_0018};
        tbl[3] = '{2'd2, 1, 32'h0000_1000, 32'h0000_0010, 32'h8000_0000, 32'd0, 1, 32'h0000_1040};
        tbl[4] = '{2'd3, 1, 32'h0000_1000, 32'h0000_0010, 32'h8000_0000, 32'd0, 0, 32'h0000_1040};
        tbl[5] = '{2'd3, 1, 32'h0000_2000, 32'hFFFF_FFFF, 32'd1, 32'd9, 1, 32'h0000_1FFC};
        tbl[6] = '{2'd2, 1, 32'h0000_0100, 32'h0000_0000, 32'd0, 32'd3, 1, 32'h0000_0100};
        tbl[7] = '{2'd3, 1, 32'h0000_0100, 32'h0000_0001, 32'd0, 32'd3, 0, 32'h0000_0104};
        tbl[8] = '{2'd0, 1, 32'hFFFF_FFFC, 32'h0000_0001, 32'd4, 32'd4, 1, 32'h0000_0000};
        tbl[9] = '{2'd0, 0, 32'h0000_0040, 32'h0000_0002, 32'd4, 32'd4, 0, 32'h0000_0048};

        // Reset clears everything, even with stall asserted.
        do_reset();
        chk("rst.valid", valid_o, 0);
        chk("rst.redirect", redirect_o, 0);
        chk("rst.target", target_o, 0);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            drive(1, tbl[i].br, tbl[i].bt, tbl[i].pc, tbl[i].imm, tbl[i].rs, tbl[i].rt);
            tick("tbl");
            chk($sformatf("tbl%0d.valid", i), valid_o, 1);
            chk($sformatf("tbl%0d.taken", i), taken_o, tbl[i].exp_tk);
            chk($sformatf("tbl%0d.target", i), target_o, tbl[i].exp_tgt);
            chk($sformatf("tbl%0d.redirect", i), redirect_o, tbl[i].exp_tk);
        end

        // Stall hold: a taken branch requests exactly one redirect.
        drive(1, 1, 2'd0, 32'h0040_0010, 32'd3, 32'd5, 32'd5);
        tick("st.load");
        chk("st.load.redirect", redirect_o, 1);
        stall_i = 1;
        pc_plus4_i = 32'h1234_5678; imm_ext_i = 32'd100; rs_data_i = 1; rt_data_i = 2;
        for (int k = 0; k < 3; k++) begin
            tick("st.hold");
            chk($sformatf("st.hold%0d.redirect", k), redirect_o, 0);
            chk($sformatf("st.hold%0d.target", k), target_o, 32'h0040_001C);
            chk($sformatf("st.hold%0d.taken", k), taken_o, 1);
        end
        drive(1, 1, 2'd1, 32'h0000_0200, 32'd1, 32'd1, 32'd2);
        tick("st.rearm");
        chk("st.rearm.redirect", redirect_o, 1);
        chk("st.rearm.target", target_o, 32'h0000_0204);

        // Flush and stall together empty the stage.
        flush_i = 1; stall_i = 1;
        tick("fs");
        chk("fs.valid", valid_o, 0);
        chk("fs.redirect", redirect_o, 0);

        // Reset in the middle of a stall.
        drive(1, 1, 2'd0, 32'h0000_0300, 32'd2, 32'd3, 32'd3);
        tick("rs.load");
        stall_i = 1;
        tick("rs.stall");
        rst_i = 1;
        tick("rs.rst");
        chk("rs.valid", valid_o, 0);
        chk("rs.taken", taken_o, 0);
        chk("rs.target", target_o, 0);
        chk("rs.pc4", pc_plus4_o, 0);
        chk("rs.redirect", redirect_o, 0);

        // Statistics: four branches retire, three of them taken.
        do_reset();
        drive(1, 1, 2'd0, 32'h10, 32'd1, 32'd1, 32'd1); tick("sx1");
        drive(1, 1, 2'd1, 32'h20, 32'd1, 32'd1, 32'd2); tick("sx2");
        drive(1, 1, 2'd0, 32'h30, 32'd1, 32'd1, 32'd2); tick("sx3");
        drive(1, 1, 2'd3, 32'h40, 32'd1, 32'd5, 32'd0); tick("sx4");
        drive(0, 0, 2'd0, 32'h50, 32'd0, 32'd0, 32'd0); tick("sx5");
        tick("sx6");
`ifdef BRANCH_STATS_EN
        chk("stats.br", br_count_o, 4);
        chk("stats.tk", tk_count_o, 3);
`else
        chk("stats.br", br_count_o, 0);
        chk("stats.tk", tk_count_o, 0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pick;
            rst_i    = ($urandom_range(63) == 0);
            flush_i  = ($urandom_range(7) == 0);
            stall_i  = ($urandom_range(3) == 0);
            valid_i  = ($urandom_range(3) != 0);
            branch_i = ($urandom_range(3) != 0);
            br_type_i  = 2'($urandom_range(3));
            pc_plus4_i = $urandom & 32'hFFFF_FFFC;
            imm_ext_i  = ($urandom_range(1) == 1) ? $urandom : 32'($signed(16'($urandom)));
            case ($urandom_range(4))
                0: pick = 32'h0;
                1: pick = 32'h1;
                2: pick = 32'hFFFF_FFFF;
                3: pick = 32'h8000_0000;
                default: pick = $urandom;
            endcase
            rs_data_i = pick;
            rt_data_i = ($urandom_range(1) == 1) ? pick : $urandom;
            tick("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
